// File: rtl/video_pkg.sv
// Shared video types and constants for the framebuffer read path.
// Contents: framebuffer geometry, scaler coordinate widths, RGB565/RGB888
// pixel structs, and the 565 -> 888 channel expansion helper.
package video_pkg;

    localparam int unsigned FB_WIDTH  = 240;
    localparam int unsigned FB_HEIGHT = 320;
    localparam int unsigned HCOUNT_W  = 11;
    localparam int unsigned VCOUNT_W  = 10;
    localparam int unsigned PIX565_W  = 16;
    localparam int unsigned CHAN_W    = 8;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
    } rgb888_t;

    // Replicate the top bits into the new LSBs so full scale maps to 0xFF.
    function automatic rgb888_t expand565(input rgb565_t pix);
        rgb888_t res;
        res.r8 = {pix.r5, pix.r5[4:2]};
        res.g8 = {pix.g6, pix.g6[5:4]};
        res.b8 = {pix.b5, pix.b5[4:2]};
        return res;
    endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// Framebuffer BRAM read port between frame_fetch and the dual-bank BRAM.
// Signals:
//   bram_addr_out  {bank, offset} read address (ADDR_W+1 bits)
//   bram_en_out    read enable
//   bram_data_in   RGB565 read data, valid BRAM_LATENCY cycles after address
// Modports: master = reader (frame_fetch), slave = memory side.
interface frame_fetch_if #(
    parameter int unsigned ADDR_W = 17
) ();
    import video_pkg::*;

    logic [ADDR_W:0]       bram_addr_out;
    logic                  bram_en_out;
    logic [PIX565_W-1:0]   bram_data_in;

    modport master (
        output bram_addr_out,
        output bram_en_out,
        input  bram_data_in
    );

    modport slave (
        input  bram_addr_out,
        input  bram_en_out,
        output bram_data_in
    );

endinterface

// File: rtl/delay_line.sv
// Fixed-depth register delay line with asynchronous active-low clear.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   i_d         data in (WIDTH bits)
//   o_q         data out, DEPTH cycles behind i_d
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_taps [DEPTH];

    // Shift register; tap 0 takes the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_taps[i] <= '0;
            end
        end else begin
            r_taps[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_taps[i] <= r_taps[i-1];
            end
        end
    end

    assign o_q = r_taps[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// Framebuffer read stage: scaled coordinates -> dual-bank BRAM address,
// BRAM latency absorbed, RGB565 expanded to RGB888 with syncs realigned,
// plus the double-buffer bank swap handshake (swaps only on vsync rise).
// Ports:
//   clk_in, rst_n_in               pixel clock, async active-low reset
//   scaled_hcount/vcount_in        framebuffer column/row
//   valid_addr_in                  coordinate inside the scaled image
//   hsync/vsync/blank_in           raw timing aligned with the coordinates
//   swap_req_in / swap_ack_out     writer frame-done level / one-cycle ack
//   bram                           BRAM read port (frame_fetch_if.master)
//   red/green/blue_out             RGB888, BRAM_LATENCY+2 cycles behind inputs
//   hsync/vsync/blank_out          timing, same latency as RGB
//   active_bank_out                bank currently being read
module frame_fetch #(
    parameter int unsigned FB_WIDTH     = video_pkg::FB_WIDTH,
    parameter int unsigned FB_HEIGHT    = video_pkg::FB_HEIGHT,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [video_pkg::HCOUNT_W-1:0]    scaled_hcount_in,
    input  logic [video_pkg::VCOUNT_W-1:0]    scaled_vcount_in,
    input  logic                              valid_addr_in,
    input  logic                              hsync_in,
    input  logic                              vsync_in,
    input  logic                              blank_in,
    input  logic                              swap_req_in,
    frame_fetch_if.master                     bram,
    output logic [video_pkg::CHAN_W-1:0]      red_out,
    output logic [video_pkg::CHAN_W-1:0]      green_out,
    output logic [video_pkg::CHAN_W-1:0]      blue_out,
    output logic                              hsync_out,
    output logic                              vsync_out,
    output logic                              blank_out,
    output logic                              swap_ack_out,
    output logic                              active_bank_out
);
    import video_pkg::*;

    localparam int unsigned PIX_LAT   = BRAM_LATENCY + 2;
    localparam int unsigned VALID_DLY = PIX_LAT - 1;
    localparam int unsigned SYNC_W    = 3;

    if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_bad_latency
        $error("frame_fetch: BRAM_LATENCY must be in 1..4");
    end
    if ((64'(1) << ADDR_W) < 64'(FB_WIDTH) * 64'(FB_HEIGHT)) begin : g_bad_addr_w
        $error("frame_fetch: ADDR_W too narrow for FB_WIDTH*FB_HEIGHT");
    end

    logic [ADDR_W-1:0]  w_offset;
    logic [ADDR_W-1:0]  w_offset_gated;
    logic               w_valid_dly;
    logic [SYNC_W-1:0]  w_sync_dly;
    logic               w_vsync_rise;
    rgb888_t            w_rgb;

    logic [ADDR_W:0]    r_bram_addr;
    logic               r_bram_en;
    logic [CHAN_W-1:0]  r_red;
    logic [CHAN_W-1:0]  r_green;
    logic [CHAN_W-1:0]  r_blue;
    logic               r_vsync_prev;
    logic               r_swap_pending;
    logic               r_swap_ack;
    logic               r_active_bank;

    // Row-major offset, product kept at ADDR_W bits.
    assign w_offset       = ADDR_W'(scaled_vcount_in) * ADDR_W'(FB_WIDTH)
                          + ADDR_W'(scaled_hcount_in);
    assign w_offset_gated = valid_addr_in ? w_offset : '0;

    // Address stage; bank bit is the bank in force this cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
        end else begin
            r_bram_addr <= {r_active_bank, w_offset_gated};
            r_bram_en   <= valid_addr_in;
        end
    end

    assign bram.bram_addr_out = r_bram_addr;
    assign bram.bram_en_out   = r_bram_en;

    // Valid lines up with returning BRAM data; output register adds the last cycle.
    delay_line #(.WIDTH(1), .DEPTH(VALID_DLY)) u_valid_dly (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .i_d   (valid_addr_in),
        .o_q   (w_valid_dly)
    );

    // Timing bits take the full pixel latency directly.
    delay_line #(.WIDTH(SYNC_W), .DEPTH(PIX_LAT)) u_sync_dly (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .i_d   ({hsync_in, vsync_in, blank_in}),
        .o_q   (w_sync_dly)
    );

    assign w_rgb = expand565(rgb565_t'(bram.bram_data_in));

    // Output stage: expanded pixel, black when the coordinate was outside.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_valid_dly) begin
            r_red   <= w_rgb.r8;
            r_green <= w_rgb.g8;
            r_blue  <= w_rgb.b8;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign w_vsync_rise = vsync_in & ~r_vsync_prev;

    // Bank swap: requests latch until the next vsync rise; same-cycle request counts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vsync_prev   <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_ack     <= 1'b0;
            r_active_bank  <= 1'b0;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_vsync_rise && (r_swap_pending || swap_req_in)) begin
                r_active_bank  <= ~r_active_bank;
                r_swap_ack     <= 1'b1;
                r_swap_pending <= 1'b0;
            end else begin
                r_swap_ack <= 1'b0;
                // Held request is still high during the ack cycle; do not re-arm.
                if (swap_req_in && !r_swap_ack) begin
                    r_swap_pending <= 1'b1;
                end
            end
        end
    end

    assign red_out         = r_red;
    assign green_out       = r_green;
    assign blue_out        = r_blue;
    assign hsync_out       = w_sync_dly[2];
    assign vsync_out       = w_sync_dly[1];
    assign blank_out       = w_sync_dly[0];
    assign swap_ack_out    = r_swap_ack;
    assign active_bank_out = r_active_bank;

endmodule
